spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SD-card style SPI master (mode 0, MSB first, 8-bit
// transfers) between two byte requesters.
//
// Ports
//   clock, reset            system clock; asynchronous active-high reset
//   reqN_valid/ready/data/hold
//                           byte request from requester N; hold=1 keeps CS
//                           low after the byte and locks the bus to N
//   rspN_valid/data         received byte for requester N, one-cycle pulse
//   spi_clk/mosi/miso/cs    SPI pins (cs active low, mosi idles high)
//   busy                    transfer in progress or bus locked
//   owner                   index of the last granted requester
//
// Parameter CLK_DIV: system clocks per SPI clock half-period (1..255).
module spi_arbiter #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic       req0_hold,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_hold,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs,
  output logic       busy,
  output logic       owner
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t     state_r, state_n;
  logic [7:0] cnt_r, cnt_n;
  logic [2:0] bit_r, bit_n;
  logic [7:0] tx_r, tx_n;
  logic [7:0] rx_r, rx_n;
  logic [7:0] rsp_data_r, rsp_data_n;
  logic       rsp0_valid_r, rsp0_valid_n;
  logic       rsp1_valid_r, rsp1_valid_n;
  logic       hold_r, hold_n;
  logic       owner_r, owner_n;
  logic       lock_r, lock_n;
  logic       ptr_r, ptr_n;
  logic       clk_r, clk_n;
  logic       mosi_r, mosi_n;
  logic       cs_r, cs_n;
  logic       busy_r, busy_n;

  logic       gnt_valid_s;
  logic       gnt_idx_s;
  logic       accept_s;
  logic [7:0] gnt_data_s;
  logic       gnt_hold_s;
  logic       cnt_done_s;

  // Arbitration: lock owner only while locked, otherwise single valid wins
  // and a tie goes to the requester named by the priority pointer.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = 1'b0;
    if (lock_r) begin
      gnt_idx_s   = owner_r;
      gnt_valid_s = owner_r ? req1_valid : req0_valid;
    end else if (req0_valid && req1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = ptr_r;
    end else if (req0_valid) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = 1'b0;
    end else if (req1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_idx_s   = 1'b0;
    end
    // Ready is held low while reset is asserted so nothing is accepted then.
    accept_s   = (state_r == ST_IDLE) && !reset && gnt_valid_s;
    req0_ready = accept_s && !gnt_idx_s;
    req1_ready = accept_s && gnt_idx_s;
    gnt_data_s = gnt_idx_s ? req1_data : req0_data;
    gnt_hold_s = gnt_idx_s ? req1_hold : req0_hold;
  end

  // Next-state and next-output computation for the SPI shifter FSM.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    bit_n        = bit_r;
    tx_n         = tx_r;
    rx_n         = rx_r;
    rsp_data_n   = rsp_data_r;
    rsp0_valid_n = 1'b0;
    rsp1_valid_n = 1'b0;
    hold_n       = hold_r;
    owner_n      = owner_r;
    lock_n       = lock_r;
    ptr_n        = ptr_r;
    clk_n        = clk_r;
    mosi_n       = mosi_r;
    cs_n         = cs_r;
    cnt_done_s   = (cnt_r == DIV_LAST);

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          tx_n    = gnt_data_s;
          hold_n  = gnt_hold_s;
          owner_n = gnt_idx_s;
          ptr_n   = ~gnt_idx_s;
          mosi_n  = gnt_data_s[7];
          cs_n    = 1'b0;
          cnt_n   = 8'd0;
          bit_n   = 3'd0;
          // A freshly selected card gets a setup half-period; a locked
          // bus already has CS low so the first bit starts at once.
          state_n = cs_r ? ST_SETUP : ST_LOW;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_done_s) begin
          cnt_n   = 8'd0;
          state_n = ST_LOW;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_LOW: begin
        if (cnt_done_s) begin
          cnt_n   = 8'd0;
          clk_n   = 1'b1;
          rx_n    = {rx_r[6:0], spi_miso};
          state_n = ST_HIGH;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_done_s) begin
          cnt_n = 8'd0;
          clk_n = 1'b0;
          if (bit_r == 3'd7) begin
            mosi_n       = 1'b1;
            rsp_data_n   = rx_r;
            rsp0_valid_n = !owner_r;
            rsp1_valid_n = owner_r;
            state_n      = ST_DONE;
          end else begin
            bit_n   = bit_r + 3'd1;
            tx_n    = {tx_r[6:0], 1'b0};
            mosi_n  = tx_r[6];
            state_n = ST_LOW;
          end
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        if (hold_r) begin
          lock_n = 1'b1;
        end else begin
          lock_n = 1'b0;
          cs_n   = 1'b1;
        end
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        clk_n   = 1'b0;
        mosi_n  = 1'b1;
        cs_n    = 1'b1;
        lock_n  = 1'b0;
      end
    endcase

    busy_n = (state_n != ST_IDLE) || lock_n;
  end

  // State and output registers; reset aborts any transfer and drops the card.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      bit_r        <= 3'd0;
      tx_r         <= 8'd0;
      rx_r         <= 8'd0;
      rsp_data_r   <= 8'd0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      hold_r       <= 1'b0;
      owner_r      <= 1'b0;
      lock_r       <= 1'b0;
      ptr_r        <= 1'b0;
      clk_r        <= 1'b0;
      mosi_r       <= 1'b1;
      cs_r         <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      bit_r        <= bit_n;
      tx_r         <= tx_n;
      rx_r         <= rx_n;
      rsp_data_r   <= rsp_data_n;
      rsp0_valid_r <= rsp0_valid_n;
      rsp1_valid_r <= rsp1_valid_n;
      hold_r       <= hold_n;
      owner_r      <= owner_n;
      lock_r       <= lock_n;
      ptr_r        <= ptr_n;
      clk_r        <= clk_n;
      mosi_r       <= mosi_n;
      cs_r         <= cs_n;
      busy_r       <= busy_n;
    end
  end

  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_data  = rsp_data_r;
  assign rsp1_data  = rsp_data_r;
  assign spi_clk    = clk_r;
  assign spi_mosi   = mosi_r;
  assign spi_cs     = cs_r;
  assign busy       = busy_r;
  assign owner      = owner_r;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed plus randomized checks of spi_arbiter with
// CLK_DIV=2. A slave model either loops MOSI back to MISO or shifts out a
// chosen byte; a small model tracks lock, owner and the priority pointer.
module tb_spi_arbiter;
  localparam int D = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_hold = 1'b0;
  logic       req1_valid = 1'b0, req1_hold = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       spi_clk, spi_mosi, spi_miso, spi_cs, busy, owner;

  spi_arbiter #(.CLK_DIV(D)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_hold(req0_hold),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_hold(req1_hold),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // SPI slave side: log MOSI at every rising SCK, present MISO bits MSB first.
  int   sck_total = 0;
  logic mosi_log [4096];
  always @(posedge spi_clk) begin
    mosi_log[sck_total[11:0]] <= spi_mosi;
    sck_total <= sck_total + 1;
  end

  logic       loop_mode = 1'b1;
  logic [7:0] slave_tx = 8'h00;
  int         sck_base = 0;
  logic [2:0] bit_idx;
  assign bit_idx  = 3'(sck_total - sck_base);
  assign spi_miso = loop_mode ? spi_mosi : slave_tx[3'd7 - bit_idx];

  int rsp0_cnt = 0, rsp1_cnt = 0;
  always @(negedge clock) begin
    if (rsp0_valid === 1'b1) rsp0_cnt <= rsp0_cnt + 1;
    if (rsp1_valid === 1'b1) rsp1_cnt <= rsp1_cnt + 1;
  end

  // Reference state: lock flag, lock owner, tie-break pointer.
  logic m_lock = 1'b0;
  int   m_owner = 0;
  int   m_ptr = 0;

  function automatic logic rdy(input int w);
    rdy = (w == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rspv(input int w);
    rspv = (w == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [7:0] rspd(input int w);
    rspd = (w == 0) ? rsp0_data : rsp1_data;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int w, input logic v, input logic [7:0] d, input logic h);
    if (w == 0) begin
      req0_valid = v; req0_data = d; req0_hold = h;
    end else begin
      req1_valid = v; req1_data = d; req1_hold = h;
    end
  endtask

  // One complete byte transfer for requester w, checked against the model.
  task automatic xfer(input int w, input logic [7:0] d, input logic h,
                      input logic lb, input logic [7:0] stx);
    int n, lat, cs_bad, oth_rdy, base0, base1, exp_lat;
    logic got;
    logic [7:0] got_d, bits;
    exp_lat = m_lock ? 1 + 16 * D : 1 + 17 * D;
    base0 = rsp0_cnt;
    base1 = rsp1_cnt;
    set_req(w, 1'b1, d, h);
    loop_mode = lb;
    slave_tx  = stx;
    oth_rdy   = 0;
    #1;
    n = 0;
    while (!rdy(w) && n < 100) begin
      if (rdy(1 - w)) oth_rdy++;
      @(negedge clock); #1;
      n++;
    end
    chk("ready_seen", rdy(w), 1);
    if (rdy(1 - w)) oth_rdy++;
    sck_base = sck_total;
    @(posedge clock); #1;
    set_req(w, 1'b0, 8'($urandom), 1'($urandom));
    chk("owner", owner, w);
    chk("busy_xfer", busy, 1);
    lat = 0; got = 1'b0; cs_bad = 0; got_d = 8'h00;
    while (!got && lat < 400) begin
      @(negedge clock);
      lat++;
      if (spi_cs !== 1'b0) cs_bad++;
      if (rdy(1 - w)) oth_rdy++;
      if (rspv(w) === 1'b1) begin
        got = 1'b1;
        got_d = rspd(w);
      end
    end
    chk("rsp_seen", got, 1);
    chk("latency", lat, exp_lat);
    chk("rsp_data", got_d, lb ? d : stx);
    chk("sck_pulses", sck_total - sck_base, 8);
    for (int i = 0; i < 8; i++) bits[7 - i] = mosi_log[12'(sck_base + i)];
    chk("mosi_bits", bits, d);
    chk("cs_low_during", cs_bad, 0);
    chk("other_ready", oth_rdy, 0);
    @(negedge clock);
    chk("cs_after", spi_cs, !h);
    chk("mosi_idle", spi_mosi, 1);
    chk("clk_idle", spi_clk, 0);
    chk("busy_after", busy, h);
    chk("rsp_own_cnt", (w == 1) ? rsp1_cnt - base1 : rsp0_cnt - base0, 1);
    chk("rsp_other_cnt", (w == 1) ? rsp0_cnt - base0 : rsp1_cnt - base1, 0);
    m_lock  = h;
    m_owner = w;
    m_ptr   = 1 - w;
  endtask

  initial begin
    int w, n, b0, b1;
    logic [7:0] d, s;
    logic h, lb;

    // Reset state, with both requesters asserting valid.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_cs", spi_cs, 1);
    chk("rst_clk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 1);
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_rsp1", rsp1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // Simultaneous pairs: winner follows the pointer, which alternates.
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1'b1, 8'h11 + 8'(k), 1'b0);
      set_req(1, 1'b1, 8'h22 + 8'(k), 1'b0);
      #1;
      chk("arb_r0", req0_ready, m_ptr == 0);
      chk("arb_r1", req1_ready, m_ptr == 1);
      chk("arb_first_is_0", m_ptr, 0);
      w = m_ptr;
      xfer(w, (w == 0) ? 8'h11 + 8'(k) : 8'h22 + 8'(k), 1'b0, 1'b1, 8'h00);
      xfer(1 - w, (w == 0) ? 8'h22 + 8'(k) : 8'h11 + 8'(k), 1'b0, 1'b1, 8'h00);
    end

    // Loopback 0xA5 from requester 0.
    xfer(0, 8'hA5, 1'b0, 1'b1, 8'h00);

    // Locked pair from requester 1 while requester 0 waits.
    xfer(1, 8'h40, 1'b1, 1'b1, 8'h00);
    set_req(0, 1'b1, 8'h5A, 1'b0);
    #1;
    chk("locked_r0", req0_ready, 0);
    chk("cs_locked_gap", spi_cs, 0);
    xfer(1, 8'h00, 1'b0, 1'b0, 8'hC3);
    xfer(0, 8'h5A, 1'b0, 1'b1, 8'h00);

    // MISO held high, then held low.
    xfer(0, 8'h3C, 1'b0, 1'b0, 8'hFF);
    xfer(1, 8'hC3, 1'b0, 1'b0, 8'h00);

    // Randomized traffic honouring any lock.
    for (int k = 0; k < 10; k++) begin
      w  = m_lock ? m_owner : int'($urandom_range(0, 1));
      d  = 8'($urandom);
      h  = 1'($urandom);
      lb = 1'($urandom);
      s  = 8'($urandom);
      xfer(w, d, h, lb, s);
    end
    if (m_lock) xfer(m_owner, 8'($urandom), 1'b0, 1'b1, 8'h00);

    // Reset in the middle of a byte.
    set_req(0, 1'b1, 8'h3C, 1'b0);
    loop_mode = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 100) begin @(negedge clock); #1; n++; end
    chk("mid_ready_seen", req0_ready, 1);
    sck_base = sck_total;
    @(posedge clock); #1;
    set_req(0, 1'b1, 8'h77, 1'b0);
    n = 0;
    while ((sck_total - sck_base) < 4 && n < 200) begin @(negedge clock); n++; end
    chk("mid_reached_bit4", sck_total - sck_base, 4);
    b0 = rsp0_cnt; b1 = rsp1_cnt;
    reset = 1'b1;
    #1;
    chk("mid_cs", spi_cs, 1);
    chk("mid_clk", spi_clk, 0);
    chk("mid_mosi", spi_mosi, 1);
    chk("mid_busy", busy, 0);
    chk("mid_ready0", req0_ready, 0);
    repeat (2) @(negedge clock);
    req0_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_no_rsp", (rsp0_cnt - b0) + (rsp1_cnt - b1), 0);
    m_lock = 1'b0; m_owner = 0; m_ptr = 0;
    xfer(0, 8'h96, 1'b0, 1'b0, 8'h69);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
